draw_background_pipelined: RTL and testbench



---
 rtl/draw_background_pipelined.sv | 279 +++++++++++++++++++++++++++
 tb/tb_draw_background_pipelined.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_background_pipelined.sv
// draw_background_pipelined
//   Pipelined oscilloscope background generator. For each VGA pixel
//   coordinate it produces a 12-bit {R,G,B} background colour. The colour
//   is made of a grid (solid or dotted), two solid centre axes, and tick
//   marks along both axes. Grid/tick positions come from incremental phase
//   counters instead of per-pixel modulo arithmetic.
//
//   Pipeline: stage 1 registers the phase counters and geometry flags.
//   Stage 2 registers the selected colour. The colour appears exactly
//   2 clocks after its coordinate, and one pixel is accepted per clock.
//
//   Mode and colours are held in shadow registers. These registers load only
//   at frame start (x==0, y==0), so the picture never tears mid-frame.
//
// Ports
//   CLK_VGA          pixel clock
//   RESETn           asynchronous active-low reset
//   VGA_HORZ_COORD   current x (+1 per clock, back to 0 each line)
//   VGA_VERT_COORD   current y (changes only when x returns to 0)
//   MODE             00 blank, 01 grid, 10 grid+axes+ticks, 11 dotted grid+axes+ticks
//   GRID_RGB         grid colour
//   AXIS_RGB         axis / tick colour
//   BG_RGB           background colour
//   VGA_*_Grid       4-bit colour channels to the overlay mux
//   COORD_ERR        sticky flag: x stepped by something other than +1 or wrap to 0
//
// DOT_LOG2 must be >= 1. Each pitch parameter must be >= 1.

module draw_background_pipelined #(
  parameter int COORD_W  = 12,
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 1024,
  parameter int H_GRID   = 80,
  parameter int V_GRID   = 64,
  parameter int H_TICK   = 16,
  parameter int V_TICK   = 8,
  parameter int H_CENTER = 640,
  parameter int V_CENTER = 512,
  parameter int TICK_LEN = 4,
  parameter int DOT_LOG2 = 2
) (
  input  logic               CLK_VGA,
  input  logic               RESETn,
  input  logic [COORD_W-1:0] VGA_HORZ_COORD,
  input  logic [COORD_W-1:0] VGA_VERT_COORD,
  input  logic [1:0]         MODE,
  input  logic [11:0]        GRID_RGB,
  input  logic [11:0]        AXIS_RGB,
  input  logic [11:0]        BG_RGB,
  output logic [3:0]         VGA_Red_Grid,
  output logic [3:0]         VGA_Green_Grid,
  output logic [3:0]         VGA_Blue_Grid,
  output logic               COORD_ERR
);

  // Phase counter widths and wrap values
  localparam int HG_W = (H_GRID > 1) ? $clog2(H_GRID) : 1;
  localparam int VG_W = (V_GRID > 1) ? $clog2(V_GRID) : 1;
  localparam int HT_W = (H_TICK > 1) ? $clog2(H_TICK) : 1;
  localparam int VT_W = (V_TICK > 1) ? $clog2(V_TICK) : 1;

  localparam logic [HG_W-1:0] HG_LAST = HG_W'(H_GRID - 1);
  localparam logic [VG_W-1:0] VG_LAST = VG_W'(V_GRID - 1);
  localparam logic [HT_W-1:0] HT_LAST = HT_W'(H_TICK - 1);
  localparam logic [VT_W-1:0] VT_LAST = VT_W'(V_TICK - 1);

  // Geometry comparisons are done on zero-extended coordinates two bits
  // wider than COORD_W. Then "coord + TICK_LEN" cannot overflow, and no
  // signed subtraction is needed for the |coord - centre| tests.
  localparam int EW = COORD_W + 2;

  localparam logic [EW-1:0] H_ACTIVE_E = EW'(H_ACTIVE);
  localparam logic [EW-1:0] V_ACTIVE_E = EW'(V_ACTIVE);
  localparam logic [EW-1:0] H_CENTER_E = EW'(H_CENTER);
  localparam logic [EW-1:0] V_CENTER_E = EW'(V_CENTER);
  localparam logic [EW-1:0] TICK_LEN_E = EW'(TICK_LEN);

  localparam logic [1:0]  MODE_RST = 2'b10;
  localparam logic [11:0] GRID_RST = 12'h0D0;
  localparam logic [11:0] AXIS_RST = 12'hFFF;
  localparam logic [11:0] BG_RST   = 12'h000;

  logic              x_zero;
  logic              y_zero;
  logic              frame_start;
  logic [EW-1:0]     x_e;
  logic [EW-1:0]     y_e;

  assign x_zero      = (VGA_HORZ_COORD == '0);
  assign y_zero      = (VGA_VERT_COORD == '0);
  assign frame_start = x_zero && y_zero;
  assign x_e         = {2'b00, VGA_HORZ_COORD};
  assign y_e         = {2'b00, VGA_VERT_COORD};

  // ---------------------------------------------------------------------
  // Shadow configuration, loaded only at frame start
  // ---------------------------------------------------------------------
  logic [1:0]  mode_q;
  logic [11:0] grid_q;
  logic [11:0] axis_q;
  logic [11:0] bg_q;

  always_ff @(posedge CLK_VGA or negedge RESETn) begin
    if (!RESETn) begin
      mode_q <= MODE_RST;
      grid_q <= GRID_RST;
      axis_q <= AXIS_RST;
      bg_q   <= BG_RST;
    end else if (frame_start) begin
      mode_q <= MODE;
      grid_q <= GRID_RGB;
      axis_q <= AXIS_RGB;
      bg_q   <= BG_RGB;
    end
  end

  // ---------------------------------------------------------------------
  // Phase counters. Each register holds the phase of the previous pixel.
  // The *_next value is the phase of the pixel currently on the inputs.
  // x==0 restarts the horizontal counters, and y==0 (seen at x==0)
  // restarts the vertical ones. This also resynchronises them after a
  // mid-frame reset.
  // ---------------------------------------------------------------------
  logic [HG_W-1:0] hg_q, hg_next;
  logic [HT_W-1:0] ht_q, ht_next;
  logic [VG_W-1:0] vg_q, vg_next;
  logic [VT_W-1:0] vt_q, vt_next;

  always_comb begin
    if (x_zero || (hg_q == HG_LAST)) hg_next = '0;
    else                             hg_next = hg_q + 1'b1;

    if (x_zero || (ht_q == HT_LAST)) ht_next = '0;
    else                             ht_next = ht_q + 1'b1;
  end

  always_comb begin
    vg_next = vg_q;
    vt_next = vt_q;
    if (x_zero) begin
      if (y_zero || (vg_q == VG_LAST)) vg_next = '0;
      else                             vg_next = vg_q + 1'b1;

      if (y_zero || (vt_q == VT_LAST)) vt_next = '0;
      else                             vt_next = vt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK_VGA or negedge RESETn) begin
    if (!RESETn) begin
      hg_q <= '0;
      ht_q <= '0;
      vg_q <= '0;
      vt_q <= '0;
    end else begin
      hg_q <= hg_next;
      ht_q <= ht_next;
      vg_q <= vg_next;
      vt_q <= vt_next;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 1 flags
  // ---------------------------------------------------------------------
  logic hg_hit_d, ht_hit_d, vg_hit_d, vt_hit_d;
  logic in_active_d, on_vaxis_d, on_haxis_d, near_vaxis_d, near_haxis_d;
  logic dot_x, dot_y, dot_on_d;

  assign hg_hit_d = (hg_next == '0);
  assign ht_hit_d = (ht_next == '0);
  assign vg_hit_d = (vg_next == '0);
  assign vt_hit_d = (vt_next == '0);

  assign in_active_d  = (x_e < H_ACTIVE_E) && (y_e < V_ACTIVE_E);
  assign on_vaxis_d   = (x_e == H_CENTER_E);
  assign on_haxis_d   = (y_e == V_CENTER_E);
  assign near_vaxis_d = ((x_e + TICK_LEN_E) >= H_CENTER_E) && (x_e <= (H_CENTER_E + TICK_LEN_E));
  assign near_haxis_d = ((y_e + TICK_LEN_E) >= V_CENTER_E) && (y_e <= (V_CENTER_E + TICK_LEN_E));

  // "low DOT_LOG2 bits < 2^(DOT_LOG2-1)" is the same as their top bit being 0.
  // A vertical grid line runs along y, so its dots follow y. A horizontal
  // grid line runs along x, so its dots follow x.
  assign dot_x    = ~VGA_HORZ_COORD[DOT_LOG2-1];
  assign dot_y    = ~VGA_VERT_COORD[DOT_LOG2-1];
  assign dot_on_d = (hg_hit_d & dot_y) | (vg_hit_d & dot_x);

  logic s1_hg_hit, s1_ht_hit, s1_vg_hit, s1_vt_hit;
  logic s1_in_active, s1_on_vaxis, s1_on_haxis, s1_near_vaxis, s1_near_haxis;
  logic s1_dot_on;

  always_ff @(posedge CLK_VGA or negedge RESETn) begin
    if (!RESETn) begin
      s1_hg_hit     <= 1'b0;
      s1_ht_hit     <= 1'b0;
      s1_vg_hit     <= 1'b0;
      s1_vt_hit     <= 1'b0;
      s1_in_active  <= 1'b0;
      s1_on_vaxis   <= 1'b0;
      s1_on_haxis   <= 1'b0;
      s1_near_vaxis <= 1'b0;
      s1_near_haxis <= 1'b0;
      s1_dot_on     <= 1'b0;
    end else begin
      s1_hg_hit     <= hg_hit_d;
      s1_ht_hit     <= ht_hit_d;
      s1_vg_hit     <= vg_hit_d;
      s1_vt_hit     <= vt_hit_d;
      s1_in_active  <= in_active_d;
      s1_on_vaxis   <= on_vaxis_d;
      s1_on_haxis   <= on_haxis_d;
      s1_near_vaxis <= near_vaxis_d;
      s1_near_haxis <= near_haxis_d;
      s1_dot_on     <= dot_on_d;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2 colour select. The shadow registers update on the same edge
  // that captures the frame-start pixel into stage 1. So that pixel (and
  // every later one) sees the new configuration here, and the pixel ahead
  // of it still sees the old configuration.
  // ---------------------------------------------------------------------
  logic        axes_on;
  logic        tick_on;
  logic        grid_on;
  logic [11:0] colour_d;
  logic [11:0] colour_q;

  assign axes_on = mode_q[1] & (s1_on_vaxis | s1_on_haxis);
  assign tick_on = mode_q[1] & ((s1_ht_hit & s1_near_haxis) | (s1_vt_hit & s1_near_vaxis));
  assign grid_on = (s1_hg_hit | s1_vg_hit) & ((mode_q != 2'b11) | s1_dot_on);

  always_comb begin
    colour_d = bg_q;
    if (!s1_in_active)        colour_d = 12'h000;
    else if (mode_q == 2'b00) colour_d = bg_q;
    else if (axes_on)         colour_d = axis_q;
    else if (tick_on)         colour_d = axis_q;
    else if (grid_on)         colour_d = grid_q;
    else                      colour_d = bg_q;
  end

  always_ff @(posedge CLK_VGA or negedge RESETn) begin
    if (!RESETn) colour_q <= 12'h000;
    else         colour_q <= colour_d;
  end

  assign VGA_Red_Grid   = colour_q[11:8];
  assign VGA_Green_Grid = colour_q[7:4];
  assign VGA_Blue_Grid  = colour_q[3:0];

  // ---------------------------------------------------------------------
  // Coordinate continuity monitor. The first pixel after reset is only
  // recorded, not checked, so releasing reset mid-line is not an error.
  // ---------------------------------------------------------------------
  logic [COORD_W-1:0] prev_x_q;
  logic [COORD_W-1:0] x_expect;
  logic               prev_valid_q;
  logic               coord_err_q;

  assign x_expect = prev_x_q + 1'b1;

  always_ff @(posedge CLK_VGA or negedge RESETn) begin
    if (!RESETn) begin
      prev_x_q     <= '0;
      prev_valid_q <= 1'b0;
      coord_err_q  <= 1'b0;
    end else begin
      prev_x_q     <= VGA_HORZ_COORD;
      prev_valid_q <= 1'b1;
      if (prev_valid_q && (VGA_HORZ_COORD != x_expect) && !x_zero)
        coord_err_q <= 1'b1;
    end
  end

  assign COORD_ERR = coord_err_q;

endmodule

// File: tb/tb_draw_background_pipelined.sv
module tb_draw_background_pipelined;

  logic        clk_vga = 1'b0;
  logic        rst_n   = 1'b1;
  logic [11:0] hx = '0;
  logic [11:0] vy = '0;
  logic [1:0]  mode_in = 2'b10;
  logic [11:0] grid_in = 12'h0D0;
  logic [11:0] axis_in = 12'hFFF;
  logic [11:0] bg_in   = 12'h000;

  logic [3:0]  ra, ga, ba, rb, gb, bb;
  logic        err_a, err_b;
  logic [11:0] rgb_a, rgb_b;

  assign rgb_a = {ra, ga, ba};
  assign rgb_b = {rb, gb, bb};

  always #5 clk_vga = ~clk_vga;

  // Default geometry
  draw_background_pipelined dut_a (
    .CLK_VGA(clk_vga), .RESETn(rst_n),
    .VGA_HORZ_COORD(hx), .VGA_VERT_COORD(vy),
    .MODE(mode_in), .GRID_RGB(grid_in), .AXIS_RGB(axis_in), .BG_RGB(bg_in),
    .VGA_Red_Grid(ra), .VGA_Green_Grid(ga), .VGA_Blue_Grid(ba),
    .COORD_ERR(err_a)
  );

  // Overridden grid pitch: columns every 100 px, rows every 50 px
  draw_background_pipelined #(.H_GRID(100), .V_GRID(50)) dut_b (
    .CLK_VGA(clk_vga), .RESETn(rst_n),
    .VGA_HORZ_COORD(hx), .VGA_VERT_COORD(vy),
    .MODE(mode_in), .GRID_RGB(grid_in), .AXIS_RGB(axis_in), .BG_RGB(bg_in),
    .VGA_Red_Grid(rb), .VGA_Green_Grid(gb), .VGA_Blue_Grid(bb),
    .COORD_ERR(err_b)
  );

  typedef struct {
    int          ph;
    int          x;
    int          y;
    logic [11:0] ea;
    logic [11:0] eb;
  } vec_t;

  vec_t        vecs[$];
  logic [11:0] got_a [64];
  logic [11:0] got_b [64];
  bit          seen  [64];
  int          cur_phase = 0;
  int          n_vec = 0;
  int          n_bad = 0;

  // Coordinate delay line matching the 2-clock DUT latency
  int p1x = -1, p1y = -1, p2x = -1, p2y = -1;

  always @(posedge clk_vga) begin
    p2x <= p1x;
    p2y <= p1y;
    p1x <= int'(hx);
    p1y <= int'(vy);
  end

  always @(negedge clk_vga) begin
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].ph == cur_phase && vecs[i].x == p2x && vecs[i].y == p2y) begin
        got_a[i] = rgb_a;
        got_b[i] = rgb_b;
        seen[i]  = 1'b1;
      end
    end
  end

  function automatic void add(int ph, int x, int y, logic [11:0] ea, logic [11:0] eb);
    vec_t v;
    v.ph = ph; v.x = x; v.y = y; v.ea = ea; v.eb = eb;
    vecs.push_back(v);
  endfunction

  function automatic int line_len(int ph, int y);
    int m = -1;
    for (int i = 0; i < vecs.size(); i++)
      if (vecs[i].ph == ph && vecs[i].y == y && vecs[i].x > m) m = vecs[i].x;
    return (m < 0) ? 2 : m + 3;
  endfunction

  task automatic chk(string name, logic [11:0] got, logic [11:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %03h, expected %03h", name, got, exp);
    end
  endtask

  task automatic drive_px(int x, int y);
    hx = x[11:0];
    vy = y[11:0];
    @(posedge clk_vga);
    #1;
  endtask

  task automatic scan_frame(int ph);
    int n;
    cur_phase = ph;
    for (int y = 0; y < 1024; y++) begin
      if (ph == 1 && y == 300) mode_in = 2'b11;
      n = line_len(ph, y);
      for (int x = 0; x < n; x++) drive_px(x, y);
    end
  endtask

  task automatic check_phase(int ph);
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].ph == ph) begin
        if (!seen[i]) begin
          n_vec++;
          n_bad++;
          $display("FAIL p%0d (%0d,%0d): pixel never observed", ph, vecs[i].x, vecs[i].y);
        end else begin
          chk($sformatf("p%0d dflt (%0d,%0d)", ph, vecs[i].x, vecs[i].y), got_a[i], vecs[i].ea);
          chk($sformatf("p%0d ovrd (%0d,%0d)", ph, vecs[i].x, vecs[i].y), got_b[i], vecs[i].eb);
        end
      end
    end
  endtask

  initial begin
    // phase, x, y, expected default DUT, expected H_GRID=100/V_GRID=50 DUT
    // 1: defaults, MODE 10 (input switches to 11 at y=300, must not apply yet)
    add(1,  200,  100, 12'h000, 12'h0D0);
    add(1,  160,  100, 12'h0D0, 12'h0D0);
    add(1,  640,    7, 12'hFFF, 12'hFFF);
    add(1,  656,  510, 12'hFFF, 12'hFFF);
    add(1,  656,  500, 12'h000, 12'h0D0);
    add(1,  100,  128, 12'h0D0, 12'h0D0);
    add(1,   80,  402, 12'h0D0, 12'h000);
    add(1,   80,    1, 12'h0D0, 12'h000);
    add(1,  100,    1, 12'h000, 12'h0D0);
    add(1,    0,   50, 12'h0D0, 12'h0D0);
    add(1, 1300,    5, 12'h000, 12'h000);
    add(1,  644,  304, 12'hFFF, 12'hFFF);
    add(1,  645,  304, 12'h000, 12'h000);
    add(1,  656,  508, 12'hFFF, 12'hFFF);
    add(1,  656,  507, 12'h000, 12'h000);
    add(1, 1279,  640, 12'h0D0, 12'h000);
    // 2: dotted grid (MODE 11), axes and ticks solid
    add(2,   80,    1, 12'h0D0, 12'h000);
    add(2,   80,    2, 12'h000, 12'h000);
    add(2,   80,    3, 12'h000, 12'h000);
    add(2,   80,    4, 12'h0D0, 12'h000);
    add(2,  161,  128, 12'h0D0, 12'h000);
    add(2,  162,  128, 12'h000, 12'h000);
    add(2,  100,    1, 12'h000, 12'h0D0);
    add(2,  100,    2, 12'h000, 12'h000);
    add(2,  640,    2, 12'hFFF, 12'hFFF);
    add(2,    3,  512, 12'hFFF, 12'hFFF);
    add(2,  656,  510, 12'hFFF, 12'hFFF);
    // 3: blank mode, BG 0x123
    add(3,  200,  100, 12'h123, 12'h123);
    add(3,  640,    7, 12'h123, 12'h123);
    add(3,    0,    0, 12'h123, 12'h123);
    add(3,  656,  510, 12'h123, 12'h123);
    add(3, 1279, 1023, 12'h123, 12'h123);
    add(3, 1300,    5, 12'h000, 12'h000);
    // 5: line after a mid-line reset; shadow back to reset defaults
    add(5,  160,  201, 12'h0D0, 12'h000);
    add(5,  640,  201, 12'hFFF, 12'hFFF);
    add(5,  200,  201, 12'h000, 12'h0D0);
    add(5,  100,  201, 12'h000, 12'h0D0);

    // Reset state
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk_vga);
    #1;
    chk("reset colour dflt", rgb_a, 12'h000);
    chk("reset colour ovrd", rgb_b, 12'h000);
    chk("reset err dflt", {11'd0, err_a}, 12'd0);
    chk("reset err ovrd", {11'd0, err_b}, 12'd0);
    rst_n = 1'b1;

    // 1..3: full-height frames
    scan_frame(1);
    check_phase(1);
    scan_frame(2);
    check_phase(2);
    mode_in = 2'b00;
    bg_in   = 12'h123;
    scan_frame(3);
    check_phase(3);

    // 4: coordinate discontinuity
    cur_phase = 4;
    for (int x = 0; x < 1280; x++) drive_px(x, 9);
    drive_px(0, 10);
    chk("wrap 1279->0 err", {11'd0, err_a}, 12'd0);
    for (int x = 1; x <= 50; x++) drive_px(x, 10);
    chk("before jump err", {11'd0, err_a}, 12'd0);
    drive_px(52, 10);
    chk("jump 50->52 err dflt", {11'd0, err_a}, 12'd1);
    chk("jump 50->52 err ovrd", {11'd0, err_b}, 12'd1);
    for (int x = 53; x < 56; x++) drive_px(x, 10);
    drive_px(0, 11);
    for (int x = 1; x < 5; x++) drive_px(x, 11);
    chk("err sticky", {11'd0, err_a}, 12'd1);

    rst_n = 1'b0;
    #1;
    chk("err cleared by reset", {11'd0, err_a}, 12'd0);
    @(posedge clk_vga);
    #1;
    rst_n = 1'b1;

    // 5: reset asserted mid-line at (500,200)
    mode_in = 2'b10;
    grid_in = 12'h0D0;
    axis_in = 12'hFFF;
    bg_in   = 12'h0A5;
    cur_phase = 5;
    for (int y = 0; y < 200; y++) begin
      drive_px(0, y);
      drive_px(1, y);
    end
    for (int x = 0; x < 500; x++) drive_px(x, 200);
    hx = 12'd500;
    chk("pre-reset (498,200) dflt", rgb_a, 12'h0A5);
    chk("pre-reset (498,200) ovrd", rgb_b, 12'h0D0);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset colour dflt", rgb_a, 12'h000);
    chk("async reset colour ovrd", rgb_b, 12'h000);
    @(posedge clk_vga);
    #1;
    drive_px(501, 200);
    drive_px(502, 200);
    rst_n = 1'b1;
    for (int x = 503; x < 600; x++) drive_px(x, 200);
    chk("after release err dflt", {11'd0, err_a}, 12'd0);
    for (int x = 0; x < line_len(5, 201); x++) drive_px(x, 201);
    drive_px(0, 202);
    drive_px(1, 202);
    check_phase(5);
    chk("line 201 err dflt", {11'd0, err_a}, 12'd0);
    chk("line 201 err ovrd", {11'd0, err_b}, 12'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
